// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Requester and memory-side bus bundle for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Environment side: requesters plus the RAM
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port arbiter (fetch / load-store) onto one fixed-latency
//               single-port RAM. Round-robin by default; define
//               MEM_ARB_FIXED_PRIO_EN for fixed priority to port 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] C_LAT  = 4'(MEM_LAT);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
            $error("mem_arbiter: MEM_LAT must be in 1..15");
        end
    endgenerate

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic w_idle;
    logic w_pick1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_resp;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign w_pick1 = bus.m1_req;
`else
    logic r_last_owner;

    // On a tie, port 1 wins only if port 0 had the previous grant
    assign w_pick1 = bus.m1_req & (~bus.m0_req | ~r_last_owner);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_owner <= 1'b1;
        end else if (w_gnt0 | w_gnt1) begin
            r_last_owner <= w_pick1;
        end
    end
`endif

    // Reset gates the combinational grant so every output is 0 in reset
    assign w_idle = (r_state == S_IDLE) & rst;
    assign w_gnt0 = w_idle & bus.m0_req & ~w_pick1;
    assign w_gnt1 = w_idle & w_pick1;
    assign w_resp = (r_state == S_RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 | w_gnt1) begin
                        r_state <= S_BUSY;
                        r_cnt   <= 4'd1;
                        r_owner <= w_pick1;
                        r_we    <= w_pick1 ? bus.m1_we    : bus.m0_we;
                        r_addr  <= w_pick1 ? bus.m1_addr  : bus.m0_addr;
                        r_wdata <= w_pick1 ? bus.m1_wdata : bus.m0_wdata;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == C_LAT) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                    if (!r_we) begin
                        if (r_owner) begin
                            r_rdata1 <= bus.mem_rdata;
                        end else begin
                            r_rdata0 <= bus.mem_rdata;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.m0_gnt    = w_gnt0;
    assign bus.m1_gnt    = w_gnt1;
    assign bus.m0_rvalid = w_resp & ~r_owner;
    assign bus.m1_rvalid = w_resp &  r_owner;

    // Read data is forwarded in the response cycle and held by the register after
    assign bus.m0_rdata  = (w_resp & ~r_owner & ~r_we) ? bus.mem_rdata : r_rdata0;
    assign bus.m1_rdata  = (w_resp &  r_owner & ~r_we) ? bus.mem_rdata : r_rdata1;

    assign bus.mem_en    = (r_state == S_BUSY) & (r_cnt == 4'd1);
    assign bus.mem_we    = bus.mem_en & r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: lane 0 runs MEM_LAT=1, lane 1 runs MEM_LAT=3, each
// with its own RAM model; a negedge scoreboard checks every transaction.
`default_nettype none

module tb_mem_arbiter;

    typedef struct {
        int          lane;
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          gcyc;
    } sb_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_err = 0;
    int   n_chk = 0;

    logic        req     [2][2];
    logic        we_i    [2][2];
    logic [31:0] addr_i  [2][2];
    logic [31:0] wdata_i [2][2];
    logic        gnt     [2][2];
    logic        rvalid  [2][2];
    logic [31:0] rdata   [2][2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];

    logic [31:0] shadow [2][256];
    logic [31:0] exp_rd [2][2];
    logic [31:0] prev   [2][2];
    int          pend   [2];
    sb_t         sb     [2][$];
    int          glog   [2][$];

`ifdef MEM_ARB_FIXED_PRIO_EN
    int exp_tie [4] = '{1, 1, 1, 1};
`else
    int exp_tie [4] = '{0, 1, 0, 1};
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar L = 0; L < 2; L++) begin : g_lane
        localparam int LATG = (L == 0) ? 1 : 3;
        mem_arbiter_if #(.AW(32), .DW(32)) bus ();
        logic [31:0] mem  [256];
        logic [31:0] pipe [LATG];

        mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LATG)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.m0_req   = req[L][0];
        assign bus.m0_we    = we_i[L][0];
        assign bus.m0_addr  = addr_i[L][0];
        assign bus.m0_wdata = wdata_i[L][0];
        assign bus.m1_req   = req[L][1];
        assign bus.m1_we    = we_i[L][1];
        assign bus.m1_addr  = addr_i[L][1];
        assign bus.m1_wdata = wdata_i[L][1];
        assign gnt[L][0]    = bus.m0_gnt;
        assign gnt[L][1]    = bus.m1_gnt;
        assign rvalid[L][0] = bus.m0_rvalid;
        assign rvalid[L][1] = bus.m1_rvalid;
        assign rdata[L][0]  = bus.m0_rdata;
        assign rdata[L][1]  = bus.m1_rdata;
        assign mem_en[L]    = bus.mem_en;
        assign mem_we[L]    = bus.mem_we;
        assign mem_addr[L]  = bus.mem_addr;
        assign mem_wdata[L] = bus.mem_wdata;
        assign bus.mem_rdata = pipe[LATG-1];

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
            mem[8'h10] = 32'hDEAD_BEEF;
            for (int k = 0; k < LATG; k++) pipe[k] = '0;
        end

        // RAM returns data exactly LATG cycles after the strobe, garbage otherwise
        always @(posedge clk) begin
            if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[7:0]] : 32'hBAD0_BAD0;
            for (int k = 1; k < LATG; k++) pipe[k] <= pipe[k-1];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int latf(input int L);
        return (L == 0) ? 1 : 3;
    endfunction

    function automatic logic [5:0] ctl(input int L);
        return {gnt[L][0], gnt[L][1], rvalid[L][0], rvalid[L][1], mem_en[L], mem_we[L]};
    endfunction

    function automatic logic [31:0] bus_or(input int L);
        return rdata[L][0] | rdata[L][1] | mem_addr[L] | mem_wdata[L];
    endfunction

    // Scoreboard and protocol monitor
    always @(negedge clk) begin
        sb_t e;
        for (int L = 0; L < 2; L++) begin
            if (!rst) begin
                sb[L].delete();
                pend[L] = 0;
                for (int p = 0; p < 2; p++) begin
                    exp_rd[L][p] = '0;
                    prev[L][p]   = rdata[L][p];
                end
            end else begin
                chk("onehot", {62'd0, gnt[L][0] & gnt[L][1], rvalid[L][0] & rvalid[L][1]}, 64'd0);
                for (int p = 0; p < 2; p++) begin
                    if (gnt[L][p]) begin
                        chk("gnt_while_pending", pend[L], 0);
                        pend[L] = 1;
                        glog[L].push_back(p);
                        e.port  = p;
                        e.we    = we_i[L][p];
                        e.addr  = addr_i[L][p];
                        e.wdata = wdata_i[L][p];
                        e.gcyc  = cyc;
                        if (e.we) begin
                            shadow[L][e.addr[7:0]] = e.wdata;
                            e.exp = exp_rd[L][p];
                        end else begin
                            e.exp = shadow[L][e.addr[7:0]];
                        end
                        exp_rd[L][p] = e.exp;
                        sb[L].push_back(e);
                    end
                end
                if (mem_en[L]) begin
                    chk("mem_en_once_per_gnt", pend[L], 1);
                    pend[L] = 0;
                    if (sb[L].size() == 0) begin
                        chk("mem_en_without_txn", 1, 0);
                    end else begin
                        e = sb[L][sb[L].size()-1];
                        chk("mem_en_cycle", cyc - e.gcyc, 1);
                        chk("mem_we", mem_we[L], e.we);
                        chk("mem_addr", mem_addr[L], e.addr);
                        if (e.we) chk("mem_wdata", mem_wdata[L], e.wdata);
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    if (rvalid[L][p]) begin
                        if (sb[L].size() == 0) begin
                            chk("rvalid_unexpected", 1, 0);
                        end else begin
                            e = sb[L].pop_front();
                            chk("rvalid_port", p, e.port);
                            chk("rdata", rdata[L][p], e.exp);
                            chk("gnt_to_rvalid", cyc - e.gcyc, latf(L) + 1);
                        end
                    end else begin
                        chk("rdata_stable", rdata[L][p], prev[L][p]);
                    end
                    prev[L][p] = rdata[L][p];
                end
            end
        end
    end

    task automatic drain(input int L);
        for (int k = 0; k < 100 && sb[L].size() > 0; k++) begin
            @(negedge clk); #1;
        end
        chk("drain_timeout", sb[L].size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v);
        int          g  = -1;
        int          r  = -1;
        logic [31:0] rd = '0;
        we_i[v.lane][v.port]    = v.we;
        addr_i[v.lane][v.port]  = v.addr;
        wdata_i[v.lane][v.port] = v.wdata;
        req[v.lane][v.port]     = 1'b1;
        for (int k = 0; k < 50 && g < 0; k++) begin
            @(negedge clk);
            if (gnt[v.lane][v.port]) g = cyc;
            @(posedge clk); #1;
        end
        req[v.lane][v.port] = 1'b0;
        for (int k = 0; k < 50 && r < 0 && g >= 0; k++) begin
            @(negedge clk);
            if (rvalid[v.lane][v.port]) begin
                r  = cyc;
                rd = rdata[v.lane][v.port];
            end
            @(posedge clk); #1;
        end
        chk("vec_rdata", rd, v.exp);
        chk("vec_latency", r - g, latf(v.lane) + 1);
    endtask

    // Both ports request simultaneously and hold until n grants are seen
    task automatic tie(input int L, input int n);
        glog[L].delete();
        we_i[L][0] = 1'b0; addr_i[L][0] = 32'h10;
        we_i[L][1] = 1'b0; addr_i[L][1] = 32'h40;
        req[L][0]  = 1'b1; req[L][1]    = 1'b1;
        for (int k = 0; k < 200 && glog[L].size() < n; k++) begin
            @(negedge clk); #1;
        end
        chk("tie_timeout", glog[L].size() >= n, 1);
        @(posedge clk); #1;
        req[L][0] = 1'b0; req[L][1] = 1'b0;
        drain(L);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [12];
        int   g0, rv, g1, cnt;

        tv[0]  = '{0, 0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};
        tv[1]  = '{1, 1, 1'b1, 32'h40, 32'h1234,      32'h0};
        tv[2]  = '{1, 1, 1'b0, 32'h40, 32'h0,         32'h1234};
        tv[3]  = '{0, 1, 1'b1, 32'h20, 32'hCAFE_0001, 32'h0};
        tv[4]  = '{0, 1, 1'b0, 32'h20, 32'h0,         32'hCAFE_0001};
        tv[5]  = '{0, 0, 1'b0, 32'h20, 32'h0,         32'hCAFE_0001};
        tv[6]  = '{1, 0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF};
        tv[7]  = '{1, 0, 1'b1, 32'hFF, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
        tv[8]  = '{1, 0, 1'b0, 32'hFF, 32'h0,         32'hFFFF_FFFF};
        tv[9]  = '{0, 0, 1'b0, 32'h33, 32'h0,         32'h1000_0033};
        tv[10] = '{0, 0, 1'b1, 32'h33, 32'h0,         32'h1000_0033};
        tv[11] = '{0, 1, 1'b0, 32'h33, 32'h0,         32'h0};

        for (int L = 0; L < 2; L++) begin
            for (int i = 0; i < 256; i++) shadow[L][i] = 32'h1000_0000 | i;
            shadow[L][8'h10] = 32'hDEAD_BEEF;
            for (int p = 0; p < 2; p++) begin
                req[L][p] = 1'b0; we_i[L][p] = 1'b0;
                addr_i[L][p] = '0; wdata_i[L][p] = '0;
            end
        end

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int L = 0; L < 2; L++) begin
            chk("reset_ctl", ctl(L), 6'd0);
            chk("reset_bus", bus_or(L), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        for (int L = 0; L < 2; L++) chk("idle_ctl", ctl(L), 6'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_vec(tv[i]);

        do_reset();
        for (int L = 0; L < 2; L++) begin
            tie(L, 4);
            for (int i = 0; i < 4; i++) begin
                if (glog[L].size() > i) chk("tie_order", glog[L][i], exp_tie[i]);
            end
        end

        // Port 1 arrives while port 0 is in BUSY on the MEM_LAT=3 lane
        g0 = -1; rv = -1; g1 = -1;
        we_i[1][0] = 1'b0; addr_i[1][0] = 32'h10; req[1][0] = 1'b1;
        for (int k = 0; k < 50 && g0 < 0; k++) begin
            @(negedge clk);
            if (gnt[1][0]) g0 = cyc;
            @(posedge clk); #1;
        end
        req[1][0] = 1'b0;
        we_i[1][1] = 1'b0; addr_i[1][1] = 32'h40; req[1][1] = 1'b1;
        for (int k = 0; k < 50 && g1 < 0; k++) begin
            @(negedge clk);
            if (rvalid[1][0]) rv = cyc;
            if (gnt[1][1]) g1 = cyc;
            @(posedge clk); #1;
        end
        req[1][1] = 1'b0;
        chk("busy_m0_latency", rv - g0, 4);
        chk("busy_m1_gnt_after_idle", g1 - rv, 1);
        drain(1);

        // Reset in the BUSY cycle after mem_en
        g0 = -1;
        we_i[1][0] = 1'b0; addr_i[1][0] = 32'h33; req[1][0] = 1'b1;
        for (int k = 0; k < 50 && g0 < 0; k++) begin
            @(negedge clk);
            if (gnt[1][0]) g0 = cyc;
            @(posedge clk); #1;
        end
        chk("midrst_gnt_seen", g0 >= 0, 1);
        req[1][0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int L = 0; L < 2; L++) begin
            chk("midrst_ctl", ctl(L), 6'd0);
            chk("midrst_bus", bus_or(L), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            cnt += int'(rvalid[1][0]) + int'(rvalid[1][1]);
        end
        chk("midrst_no_rvalid", cnt, 0);
        @(posedge clk); #1;
        tie(1, 1);
        if (glog[1].size() > 0) chk("midrst_tie_first", glog[1][0], exp_tie[0]);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
